// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the CORDIC channel scheduler.
// Holds the FSM state enum, the angle width and the phase-wrap rule.
package cordic_sched_pkg;

  localparam int ANGLE_W = 8;
  localparam logic signed [ANGLE_W-1:0] ANGLE_MAX_DEF = 8'sd127;
  localparam logic signed [ANGLE_W-1:0] ANGLE_MIN_DEF = -8'sd74;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    CAPTURE
  } state_e;

  // Two guard bits let phase+step be compared as signed without overflow.
  function automatic logic signed [ANGLE_W-1:0] phase_next(
    input logic signed [ANGLE_W-1:0] phase,
    input logic [ANGLE_W-1:0]        step,
    input logic signed [ANGLE_W-1:0] amax,
    input logic signed [ANGLE_W-1:0] amin
  );
    logic signed [ANGLE_W+1:0] sum;
    sum = {{2{phase[ANGLE_W-1]}}, phase} + {2'b00, step};
    if (sum > $signed({{2{amax[ANGLE_W-1]}}, amax})) return amin;
    return sum[ANGLE_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_scheduler_if.sv
// Start/done handshake between the scheduler (master) and the shared CORDIC core (slave).
interface cordic_scheduler_if;

  logic                                        cordic_rst;
  logic signed [cordic_sched_pkg::ANGLE_W-1:0] cordic_angle;
  logic                                        cordic_done;
  logic        [cordic_sched_pkg::ANGLE_W-1:0] cordic_result;

  modport master (
    output cordic_rst,
    output cordic_angle,
    input  cordic_done,
    input  cordic_result
  );

  modport slave (
    input  cordic_rst,
    input  cordic_angle,
    output cordic_done,
    output cordic_result
  );

endinterface

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Round-robin grant: first requester strictly above last_grant, else lowest requester.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant_oh,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_vld
);

  logic [NUM_CH-1:0] hi_req;

  always_comb begin
    hi_req    = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    grant_oh  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hi_req[i] = req[i] && (i > int'(last_grant));
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = IDX_W'(i);
        grant_vld = 1'b1;
      end
    end
    // Requests above the previous winner take precedence over the wrap-around pick.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hi_req[i]) grant_idx = IDX_W'(i);
    end
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Time-shares one CORDIC core among NUM_CH phase-accumulating angle channels.
// Sticky timeout_err flags a core that never completes.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no work; leave when any channel is enabled
// ARB       | round-robin grant, latch grant and present its phase
// ISSUE     | one-cycle cordic_rst, arm the timeout counter
// WAIT_LOW  | wait for done to drop (rejects a leftover done level)
// WAIT_HIGH | wait for done to rise
// CAPTURE   | store result, strobe chan_valid, advance phase
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int                        NUM_CH    = 2,
  parameter logic signed [ANGLE_W-1:0] ANGLE_MAX = ANGLE_MAX_DEF,
  parameter logic signed [ANGLE_W-1:0] ANGLE_MIN = ANGLE_MIN_DEF,
  parameter int                        TIMEOUT   = 64
) (
  input  logic                        DAC_clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic [ANGLE_W*NUM_CH-1:0]   ch_step,
  cordic_scheduler_if.master          core,
  output logic [ANGLE_W*NUM_CH-1:0]   chan_data,
  output logic [NUM_CH-1:0]           chan_valid,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CH - 1);

  state_e                     state, state_nxt;
  logic [IDX_W-1:0]           grant, last_grant, arb_idx;
  logic [NUM_CH-1:0]          grant_oh, arb_oh;
  logic                       arb_vld;
  logic signed [ANGLE_W-1:0]  phase [NUM_CH];
  logic signed [ANGLE_W-1:0]  angle_q;
  logic [TMO_W-1:0]           tmo_cnt;
  logic                       tmo_tc;
  logic                       do_grant, do_capture, do_timeout;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr_arbiter (
    .req        (ch_en),
    .last_grant (last_grant),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx),
    .grant_vld  (arb_vld)
  );

  assign tmo_tc = (tmo_cnt == '0);

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE:      if (|ch_en) state_nxt = ARB;
      ARB: begin
        if (arb_vld) begin
          do_grant  = 1'b1;
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE:     state_nxt = WAIT_LOW;
      WAIT_LOW: begin
        if (tmo_tc) begin
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end else if (!core.cordic_done) begin
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (tmo_tc) begin
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end else if (core.cordic_done) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        do_capture = 1'b1;
        state_nxt  = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  assign busy            = (state != IDLE);
  assign core.cordic_rst = (state == ISSUE);
  // The granted phase is shown combinationally in ARB so the angle is valid from ARB onward.
  assign core.cordic_angle = (state == ARB && arb_vld) ? phase[arb_idx] : angle_q;

  always_ff @(posedge DAC_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_oh    <= '0;
      last_grant  <= LAST_RST;
      angle_q     <= '0;
      tmo_cnt     <= '0;
      chan_data   <= '0;
      chan_valid  <= '0;
      timeout_err <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) phase[k] <= '0;
    end else begin
      state      <= state_nxt;
      chan_valid <= '0;
      if (do_grant) begin
        grant    <= arb_idx;
        grant_oh <= arb_oh;
        angle_q  <= phase[arb_idx];
      end
      if (state == ISSUE) begin
        tmo_cnt <= TMO_W'(TIMEOUT - 1);
      end else if ((state == WAIT_LOW || state == WAIT_HIGH) && !tmo_tc) begin
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      end
      if (do_capture) begin
        chan_data[int'(grant)*ANGLE_W +: ANGLE_W] <= core.cordic_result;
        chan_valid   <= grant_oh;
        phase[grant] <= phase_next(phase[grant], ch_step[int'(grant)*ANGLE_W +: ANGLE_W],
                                   ANGLE_MAX, ANGLE_MIN);
        last_grant   <= grant;
      end
      if (do_timeout) begin
        timeout_err <= 1'b1;
        last_grant  <= grant;
      end
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Self-checking bench for cordic_scheduler: behavioural core model plus a
// channel-level reference (round-robin order, phase arithmetic, stored results).
module tb_cordic_scheduler;
  import cordic_sched_pkg::*;

  localparam int NUM_CH  = 2;
  localparam int TIMEOUT = 64;

  logic                   DAC_clk = 1'b0;
  logic                   rst_n;
  logic [NUM_CH-1:0]      ch_en;
  logic [8*NUM_CH-1:0]    ch_step;
  logic [8*NUM_CH-1:0]    chan_data;
  logic [NUM_CH-1:0]      chan_valid;
  logic                   busy;
  logic                   timeout_err;

  cordic_scheduler_if cif ();

  cordic_scheduler #(
    .NUM_CH    (NUM_CH),
    .ANGLE_MAX (8'sd127),
    .ANGLE_MIN (-8'sd74),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .DAC_clk     (DAC_clk),
    .rst_n       (rst_n),
    .ch_en       (ch_en),
    .ch_step     (ch_step),
    .core        (cif),
    .chan_data   (chan_data),
    .chan_valid  (chan_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 DAC_clk = ~DAC_clk;

  int n_pass = 0;
  int n_chk  = 0;

  // channel-level reference state
  int         ref_phase [NUM_CH];
  logic [7:0] ref_data  [NUM_CH];
  int         ref_last;

  // core model controls
  int         core_lat   = 4;
  bit         core_stale = 1'b0;
  bit         core_never = 1'b0;
  int         core_cnt   = 0;
  logic [7:0] core_res_v = 8'h00;
  int         overlap_cnt = 0;

  function automatic void ref_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      ref_phase[i] = 0;
      ref_data[i]  = 8'h00;
    end
    ref_last = NUM_CH - 1;
  endfunction

  function automatic int ref_next_grant(input logic [NUM_CH-1:0] en);
    for (int i = 1; i <= NUM_CH; i++) begin
      int c;
      c = (ref_last + i) % NUM_CH;
      if (en[c]) return c;
    end
    return -1;
  endfunction

  function automatic int ref_phase_upd(input int p, input int s);
    int sum;
    sum = p + s;
    if (sum > 127) return -74;
    return sum;
  endfunction

  function automatic logic [8*NUM_CH-1:0] ref_data_vec();
    logic [8*NUM_CH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*8 +: 8] = ref_data[i];
    return v;
  endfunction

  // CORDIC core: drops done on start, raises it with a fresh result core_lat cycles later.
  initial begin
    cif.cordic_done   = 1'b0;
    cif.cordic_result = 8'h00;
    forever begin
      @(negedge DAC_clk);
      if (!rst_n) begin
        cif.cordic_done = 1'b0;
        core_cnt = 0;
      end else if (cif.cordic_rst) begin
        if (!core_stale) cif.cordic_done = 1'b0;
        core_cnt = core_never ? 0 : core_lat;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_stale && core_cnt == 3) cif.cordic_done = 1'b0;
        if (core_cnt == 0) begin
          core_res_v        = 8'($urandom);
          cif.cordic_result = core_res_v;
          cif.cordic_done   = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge DAC_clk);
      if ($countones(chan_valid) > 1) overlap_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  // One full operation: expects the reference's next grant, checks angle, gap, latency, data.
  task automatic run_op(input int lat, input bit stale, input bit chg_step, input bit drop_en,
                        input int exp_gap, output int got_ch, output logic [7:0] got_ang);
    int exp_ch, waited;
    bit seen;
    logic [NUM_CH-1:0] exp_vld;
    got_ch  = -1;
    got_ang = 8'h00;
    exp_ch  = ref_next_grant(ch_en);
    core_lat   = lat;
    core_stale = stale;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 40) begin
      @(negedge DAC_clk);
      waited++;
      seen = cif.cordic_rst;
    end
    n_chk++;
    if (!seen || exp_ch < 0) begin
      $display("FAIL op_issue: cordic_rst seen=%0b after %0d cycles, expected grant ch %0d", seen, waited, exp_ch);
      return;
    end
    n_pass++;
    got_ang = cif.cordic_angle;
    n_chk++;
    if (int'($signed(got_ang)) !== ref_phase[exp_ch])
      $display("FAIL op_angle: ch %0d angle got %0d want %0d", exp_ch, $signed(got_ang), ref_phase[exp_ch]);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b1) $display("FAIL op_busy: busy got %b want 1", busy);
    else n_pass++;
    if (exp_gap > 0) begin
      n_chk++;
      if (waited !== exp_gap) $display("FAIL op_gap: valid-to-issue got %0d want %0d", waited, exp_gap);
      else n_pass++;
    end
    if (chg_step) ch_step[exp_ch*8 +: 8] = 8'($urandom);
    if (drop_en) ch_en = '0;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 200) begin
      @(negedge DAC_clk);
      waited++;
      seen = |chan_valid;
    end
    n_chk++;
    if (!seen) begin
      $display("FAIL op_valid: no chan_valid within %0d cycles for ch %0d", waited, exp_ch);
      return;
    end
    n_pass++;
    n_chk++;
    if (waited !== lat + 2) $display("FAIL op_latency: issue-to-valid got %0d want %0d", waited, lat + 2);
    else n_pass++;
    exp_vld = '0;
    exp_vld[exp_ch] = 1'b1;
    n_chk++;
    if (chan_valid !== exp_vld) $display("FAIL op_valid_ch: chan_valid got %b want %b", chan_valid, exp_vld);
    else n_pass++;
    ref_data[exp_ch] = core_res_v;
    n_chk++;
    if (chan_data !== ref_data_vec()) $display("FAIL op_data: chan_data got %h want %h", chan_data, ref_data_vec());
    else n_pass++;
    for (int i = 0; i < NUM_CH; i++) if (chan_valid[i]) got_ch = i;
    ref_phase[exp_ch] = ref_phase_upd(ref_phase[exp_ch], int'(ch_step[exp_ch*8 +: 8]));
    ref_last = exp_ch;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    ch_en   = '0;
    ch_step = '0;
    repeat (3) @(negedge DAC_clk);
    n_chk++;
    if (busy !== 1'b0 || cif.cordic_rst !== 1'b0) $display("FAIL reset_ctl: busy=%b cordic_rst=%b want 0 0", busy, cif.cordic_rst);
    else n_pass++;
    n_chk++;
    if (cif.cordic_angle !== 8'h00) $display("FAIL reset_angle: got %h want 00", cif.cordic_angle);
    else n_pass++;
    n_chk++;
    if (chan_data !== '0 || chan_valid !== '0) $display("FAIL reset_chan: data=%h valid=%b want 0", chan_data, chan_valid);
    else n_pass++;
    n_chk++;
    if (timeout_err !== 1'b0) $display("FAIL reset_err: timeout_err got %b want 0", timeout_err);
    else n_pass++;
    rst_n = 1'b1;
    ref_reset();
    repeat (2) @(negedge DAC_clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0 with ch_en=0", busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int ch;
    logic [7:0] ang;
    bit rst_seen;
    ch_en = 2'b01;
    ch_step[7:0] = 8'd1;
    for (int i = 0; i < 4; i++) begin
      run_op(4, 1'b0, 1'b0, (i == 3), (i == 0) ? 0 : 2, ch, ang);
      n_chk++;
      if (ang !== 8'(i)) $display("FAIL single_seq: op %0d angle got %0d want %0d", i, ang, i);
      else n_pass++;
    end
    rst_seen = 1'b0;
    repeat (4) begin
      @(negedge DAC_clk);
      if (cif.cordic_rst) rst_seen = 1'b1;
    end
    n_chk++;
    if (busy !== 1'b0 || rst_seen) $display("FAIL single_drop: busy=%b issued=%b want 0 0 after ch_en drop", busy, rst_seen);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int ch;
    logic [7:0] a [6];
    ch_en = 2'b01;
    ch_step[7:0] = 8'(126 - ref_phase[0]);
    run_op(3, 1'b0, 1'b0, 1'b0, 0, ch, a[0]);
    ch_step[7:0] = 8'd1;
    run_op(3, 1'b0, 1'b0, 1'b0, 2, ch, a[1]);
    run_op(5, 1'b0, 1'b0, 1'b0, 2, ch, a[2]);
    run_op(2, 1'b0, 1'b0, 1'b0, 2, ch, a[3]);
    ch_step[7:0] = 8'd0;
    run_op(3, 1'b0, 1'b0, 1'b0, 2, ch, a[4]);
    run_op(3, 1'b0, 1'b0, 1'b0, 2, ch, a[5]);
    ch_en = '0;
    n_chk++;
    if (a[1] !== 8'd126 || a[2] !== 8'd127) $display("FAIL wrap_pre: angles got %0d %0d want 126 127", a[1], a[2]);
    else n_pass++;
    n_chk++;
    if (a[3] !== 8'hB6) $display("FAIL wrap_min: angle got %h want b6", a[3]);
    else n_pass++;
    n_chk++;
    if (a[5] !== a[4] || a[4] !== 8'hB7) $display("FAIL wrap_step0: angles got %h %h want b7 b7", a[4], a[5]);
    else n_pass++;
  endtask

  task automatic test_stale();
    int ch;
    logic [7:0] ang;
    ch_en = 2'b01;
    ch_step[7:0] = 8'd3;
    run_op(6, 1'b1, 1'b0, 1'b0, 0, ch, ang);
    run_op(7, 1'b1, 1'b0, 1'b0, 2, ch, ang);
    run_op(4, 1'b0, 1'b0, 1'b0, 2, ch, ang);
    ch_en = '0;
  endtask

  task automatic test_back_to_back();
    int ch, prev;
    logic [7:0] ang;
    ch_en = 2'b11;
    ch_step[7:0]  = 8'($urandom_range(1, 255));
    ch_step[15:8] = 8'($urandom_range(1, 255));
    prev = -1;
    for (int i = 0; i < 10; i++) begin
      run_op($urandom_range(2, 8), 1'b0, 1'($urandom_range(0, 1)), 1'b0, (i == 0) ? 0 : 2, ch, ang);
      if (prev >= 0) begin
        n_chk++;
        if (ch !== 1 - prev) $display("FAIL fair_alt: op %0d grant got %0d want %0d", i, ch, 1 - prev);
        else n_pass++;
      end
      prev = ch;
      if (ch_step[7:0] == 8'd0) ch_step[7:0] = 8'd1;
      if (ch_step[15:8] == 8'd0) ch_step[15:8] = 8'd1;
    end
    for (int i = 0; i < 10; i++) begin
      ch_en   = 2'($urandom_range(1, 3));
      ch_step = 16'($urandom);
      run_op($urandom_range(2, 8), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 2, ch, ang);
    end
    ch_en = '0;
    n_chk++;
    if (overlap_cnt !== 0) $display("FAIL fair_overlap: cycles with >1 chan_valid got %0d want 0", overlap_cnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int tch, cnt, ch, waited;
    bit seen, vld;
    logic [7:0] tang, ang;
    ch_en = 2'b11;
    tch = ref_next_grant(ch_en);
    core_never = 1'b1;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 40) begin
      @(negedge DAC_clk);
      waited++;
      seen = cif.cordic_rst;
    end
    tang = cif.cordic_angle;
    core_never = 1'b0;
    cnt = 0;
    vld = 1'b0;
    while (!timeout_err && cnt < 200) begin
      @(negedge DAC_clk);
      cnt++;
      if (|chan_valid) vld = 1'b1;
    end
    n_chk++;
    if (!seen || cnt !== TIMEOUT + 1) $display("FAIL tmo_cycles: issue=%0b err after %0d cycles want %0d", seen, cnt, TIMEOUT + 1);
    else n_pass++;
    n_chk++;
    if (vld || chan_data !== ref_data_vec()) $display("FAIL tmo_nocap: valid=%b data got %h want %h", vld, chan_data, ref_data_vec());
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL tmo_idle: busy got %b want 0", busy);
    else n_pass++;
    ref_last = tch;
    run_op(3, 1'b0, 1'b0, 1'b0, 2, ch, ang);
    n_chk++;
    if (ch !== 1 - tch) $display("FAIL tmo_next: grant got %0d want %0d", ch, 1 - tch);
    else n_pass++;
    run_op(3, 1'b0, 1'b0, 1'b0, 2, ch, ang);
    ch_en = '0;
    n_chk++;
    if (ang !== tang) $display("FAIL tmo_phase: angle got %h want unchanged %h", ang, tang);
    else n_pass++;
    repeat (3) @(negedge DAC_clk);
    n_chk++;
    if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: timeout_err got %b want 1", timeout_err);
    else n_pass++;
  endtask

  task automatic test_reset_wait_high();
    int ch, waited;
    bit seen, vld;
    logic [7:0] ang;
    ch_en = 2'b11;
    core_lat = 12;
    core_stale = 1'b0;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 40) begin
      @(negedge DAC_clk);
      waited++;
      seen = cif.cordic_rst;
    end
    repeat (3) @(negedge DAC_clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (!seen || busy !== 1'b0 || cif.cordic_rst !== 1'b0 || cif.cordic_angle !== 8'h00)
      $display("FAIL rstwh_ctl: issue=%0b busy=%b cordic_rst=%b angle=%h want 1 0 0 00", seen, busy, cif.cordic_rst, cif.cordic_angle);
    else n_pass++;
    n_chk++;
    if (chan_data !== '0 || chan_valid !== '0 || timeout_err !== 1'b0)
      $display("FAIL rstwh_out: data=%h valid=%b err=%b want 0 0 0", chan_data, chan_valid, timeout_err);
    else n_pass++;
    vld = 1'b0;
    repeat (3) begin
      @(negedge DAC_clk);
      if (|chan_valid) vld = 1'b1;
    end
    rst_n = 1'b1;
    ref_reset();
    run_op(4, 1'b0, 1'b0, 1'b0, 0, ch, ang);
    ch_en = '0;
    n_chk++;
    if (vld || ch !== 0 || ang !== 8'h00) $display("FAIL rstwh_next: valid_in_rst=%b grant=%0d angle=%h want 0 0 00", vld, ch, ang);
    else n_pass++;
    n_chk++;
    if (timeout_err !== 1'b0) $display("FAIL rstwh_err: timeout_err got %b want 0", timeout_err);
    else n_pass++;
  endtask

  initial begin
    rst_n   = 1'b0;
    ch_en   = '0;
    ch_step = '0;
    ref_reset();
    test_reset();
    test_single();
    test_wrap();
    test_stale();
    test_back_to_back();
    test_timeout();
    test_reset_wait_high();
    repeat (2) @(negedge DAC_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_scheduler.md
CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_CH, 2, number of angle channels sharing one CORDIC core.
- ANGLE_MAX, 8'sd127, last legal angle before wrap.
- ANGLE_MIN, -8'sd74 (8'hB6), wrap target angle.
- TIMEOUT, 64, maximum cycles to wait for done.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- DAC_clk, in, 1: the single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- ch_en, in, NUM_CH: channel enable (request).
- ch_step, in, 8*NUM_CH: unsigned per-channel phase increment; channel k uses bits [8k+7:8k].
- cordic_rst, out, 1: one-cycle start pulse to the CORDIC core.
- cordic_angle, out, 8 signed: angle presented to the core.
- cordic_done, in, 1: level-high completion from the core.
- cordic_result, in, 8: core output.
- chan_data, out, 8*NUM_CH: last result per channel.
- chan_valid, out, NUM_CH: one-cycle strobe when chan_data[k] updates.
- busy, out, 1: high whenever the FSM is not in IDLE.
- timeout_err, out, 1: sticky error flag.

Function
REQ-003 The FSM SHALL have states IDLE, ARB, ISSUE, WAIT_LOW, WAIT_HIGH and CAPTURE.
REQ-004 IDLE SHALL go to ARB when any ch_en bit is set; otherwise it SHALL stay in IDLE.
REQ-005 ARB SHALL grant one enabled channel by round-robin, searching from (last_grant+1) mod NUM_CH. It SHALL latch the grant and drive cordic_angle with that channel's phase register, then go to ISSUE. If ch_en has dropped to all-zero, ARB SHALL return to IDLE.
REQ-006 ISSUE SHALL assert cordic_rst for exactly one cycle, clear the timeout counter, and go to WAIT_LOW.
REQ-007 WAIT_LOW SHALL ignore cordic_done until it is sampled low, then go to WAIT_HIGH. This rejects a done level left over from the previous operation.
REQ-008 WAIT_HIGH SHALL go to CAPTURE on the first cycle cordic_done is sampled high.
REQ-009 cordic_angle SHALL hold stable from ARB through CAPTURE.
REQ-010 CAPTURE SHALL, in one cycle:
- write cordic_result to chan_data[grant];
- pulse chan_valid[grant];
- update phase[grant];
- set last_grant to grant;
- return to IDLE.
REQ-011 Phase update SHALL compute sum = phase + step as a 10-bit signed value. If sum > ANGLE_MAX, phase SHALL become ANGLE_MIN; otherwise phase SHALL become sum[7:0]. step = 0 SHALL leave phase unchanged.
REQ-012 The timeout counter SHALL count cycles spent in WAIT_LOW plus WAIT_HIGH. On reaching TIMEOUT, the FSM SHALL set timeout_err, leave chan_data and phase unchanged, set last_grant to grant, and go to IDLE.
REQ-013 timeout_err SHALL clear only on reset.
REQ-014 A channel whose ch_en is deasserted mid-operation SHALL still complete its current operation and be captured normally.
REQ-015 ch_step SHALL be sampled in CAPTURE, not in ARB.
REQ-016 End-to-end latency from ARB to chan_valid SHALL be 3 cycles plus the core latency; a back-to-back grant SHALL occur no sooner than 2 cycles after CAPTURE.
REQ-017 At most one chan_valid bit SHALL be high in any cycle.

Reset
REQ-018 On rst_n low, all outputs and state SHALL clear asynchronously:
- state = IDLE, last_grant = NUM_CH-1;
- all phase registers = 0, chan_data = 0;
- chan_valid = 0, cordic_rst = 0, cordic_angle = 0;
- busy = 0, timeout_err = 0.
REQ-019 Reset asserted mid-operation SHALL abort without capture. The first arbitration after release SHALL grant channel 0 if it is enabled.

Structure
REQ-020 Package cordic_sched_pkg SHALL hold the state enum, the ANGLE_MAX and ANGLE_MIN defaults, and the angle/data width constant (8).
REQ-021 The round-robin grant logic SHALL be a separate sub-module, rr_arbiter (inputs: request vector and last_grant; output: one-hot grant plus index). The phase accumulators and FSM SHALL stay in cordic_scheduler.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single channel: ch_en=01, step0=1, core done 4 cycles after cordic_rst -> chan_valid[0] pulses, cordic_angle sequence 0,1,2,...
- Wrap: phase0=126, step0=1 -> angles 126, 127, then -74 (8'hB6).
- Fairness: ch_en=11, both steps nonzero -> grants alternate 0,1,0,1 and chan_valid never overlaps.
- Stale done: done held high through ISSUE -> no capture until done goes low then high again.
- Timeout: core never raises done -> timeout_err=1 after 64 wait cycles, phase unchanged, next grant goes to the other channel, flag stays set.
- Reset in WAIT_HIGH: rst_n pulsed low -> all outputs 0 immediately, no chan_valid, next grant is channel 0.
